// File: rtl/contour_pkg.sv
// contour_pkg: definitions shared by the contour readback logic.
// Holds the default frame geometry, field widths for addresses, labels, counts and sums,
// the reader FSM state type, the coordinate tag carried alongside BRAM reads, and the
// per-bin statistics record.
package contour_pkg;

    localparam int unsigned FRAME_WIDTH  = 640;
    localparam int unsigned FRAME_HEIGHT = 480;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned BIN_W        = 3;
    localparam int unsigned X_W          = 10;
    localparam int unsigned Y_W          = 9;
    localparam int unsigned CNT_W        = 19;
    localparam int unsigned SUM_X_W      = 28;
    localparam int unsigned SUM_Y_W      = 27;

    localparam logic [BIN_W-1:0] NO_EDGE_BIN = '0;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StScan,
        StFlush,
        StDrain,
        StDone
    } cbr_state_e;

    // Coordinate of an issued read, delayed to line up with the returned label.
    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_tag_t;

    typedef struct packed {
        logic [CNT_W-1:0]   count;
        logic [X_W-1:0]     xmin;
        logic [X_W-1:0]     xmax;
        logic [Y_W-1:0]     ymin;
        logic [Y_W-1:0]     ymax;
        logic [SUM_X_W-1:0] sum_x;
        logic [SUM_Y_W-1:0] sum_y;
    } bin_stats_t;

endpackage

// File: rtl/coord_delay_line.sv
// coord_delay_line: READ_LATENCY-deep shift register carrying {valid, x, y} so that the
// coordinate of each issued BRAM address emerges on the cycle its data returns.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of every stage (drops in-flight reads of an aborted scan)
//   tag_in      coordinate tag of the address issued this cycle
//   tag_out     tag of the address issued READ_LATENCY cycles ago
module coord_delay_line
    import contour_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2  // must be >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  coord_tag_t tag_in,
    output coord_tag_t tag_out
);

    coord_tag_t stage_q [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/contour_bin_reader.sv
// contour_bin_reader: raster-scans the bin-labelled edge BRAM once, accumulates per-label
// (1..MAX_BIN) pixel count and bounding box, then streams one record per non-empty bin.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               level; rising edge in IDLE starts a scan, low anywhere aborts
//   done                high after the last record is accepted, until start drops
//   bram_addr_read      BRAM read address, bram_read returns the label READ_LATENCY later
//   res_valid/res_ready record handshake
//   res_bin, res_count, res_xmin/xmax, res_ymin/ymax  record fields (0 while !res_valid)
//   res_sum_x, res_sum_y  coordinate sums, only with CONTOUR_BIN_READER_CENTROID_EN
// Build option: define CONTOUR_BIN_READER_CENTROID_EN to add per-bin coordinate sums;
// otherwise no sum state exists and res_sum_x/res_sum_y are 0.
// MAX_BIN must not exceed 2**BIN_W-1.
module contour_bin_reader
    import contour_pkg::*;
#(
    parameter int unsigned WIDTH        = FRAME_WIDTH,
    parameter int unsigned HEIGHT       = FRAME_HEIGHT,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_BIN      = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               done,
    output logic [ADDR_W-1:0]  bram_addr_read,
    input  logic [BIN_W-1:0]   bram_read,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BIN_W-1:0]   res_bin,
    output logic [CNT_W-1:0]   res_count,
    output logic [X_W-1:0]     res_xmin,
    output logic [X_W-1:0]     res_xmax,
    output logic [Y_W-1:0]     res_ymin,
    output logic [Y_W-1:0]     res_ymax,
    output logic [SUM_X_W-1:0] res_sum_x,
    output logic [SUM_Y_W-1:0] res_sum_y
);

    localparam logic [X_W-1:0]    XLast     = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    YLast     = Y_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [BIN_W-1:0]  MaxBin    = BIN_W'(MAX_BIN);
    localparam int unsigned       FlushW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [FlushW-1:0] FlushLast = FlushW'(READ_LATENCY - 1);

    cbr_state_e         state_q;
    logic               start_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [FlushW-1:0]  flush_q;
    logic [BIN_W-1:0]   bin_q;
    logic               res_valid_q;
    logic               done_q;

    // Per-bin tables, index = bin label.
    logic [CNT_W-1:0]   cnt_q  [1:MAX_BIN];
    logic [X_W-1:0]     xmin_q [1:MAX_BIN];
    logic [X_W-1:0]     xmax_q [1:MAX_BIN];
    logic [Y_W-1:0]     ymin_q [1:MAX_BIN];
    logic [Y_W-1:0]     ymax_q [1:MAX_BIN];
`ifdef CONTOUR_BIN_READER_CENTROID_EN
    logic [SUM_X_W-1:0] sum_x_q [1:MAX_BIN];
    logic [SUM_Y_W-1:0] sum_y_q [1:MAX_BIN];
`endif

    coord_tag_t             tag_in;
    coord_tag_t             tag_out;
    logic                   acc_hit;
    bin_stats_t             sel;
    logic [2**BIN_W-1:0]    nonempty;
    logic [BIN_W-1:0]       next_bin;

    assign tag_in.valid = (state_q == StScan);
    assign tag_in.x     = x_q;
    assign tag_in.y     = y_q;

    // Clearing in IDLE guarantees reads still in flight from an aborted scan never land.
    coord_delay_line #(
        .READ_LATENCY(READ_LATENCY)
    ) u_coord_delay_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == StIdle),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign acc_hit = tag_out.valid && (bram_read != NO_EDGE_BIN) && (bram_read <= MaxBin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 1; b <= int'(MAX_BIN); b++) begin
                cnt_q[b]  <= '0;
                xmin_q[b] <= XLast;
                xmax_q[b] <= '0;
                ymin_q[b] <= YLast;
                ymax_q[b] <= '0;
`ifdef CONTOUR_BIN_READER_CENTROID_EN
                sum_x_q[b] <= '0;
                sum_y_q[b] <= '0;
`endif
            end
        end else begin
            for (int b = 1; b <= int'(MAX_BIN); b++) begin
                if (state_q == StClear) begin
                    cnt_q[b]  <= '0;
                    xmin_q[b] <= XLast;
                    xmax_q[b] <= '0;
                    ymin_q[b] <= YLast;
                    ymax_q[b] <= '0;
`ifdef CONTOUR_BIN_READER_CENTROID_EN
                    sum_x_q[b] <= '0;
                    sum_y_q[b] <= '0;
`endif
                end else if (acc_hit && (bram_read == BIN_W'(b))) begin
                    if (cnt_q[b] != '1) begin
                        cnt_q[b] <= cnt_q[b] + 1'b1;
                    end
                    if (tag_out.x < xmin_q[b]) xmin_q[b] <= tag_out.x;
                    if (tag_out.x > xmax_q[b]) xmax_q[b] <= tag_out.x;
                    if (tag_out.y < ymin_q[b]) ymin_q[b] <= tag_out.y;
                    if (tag_out.y > ymax_q[b]) ymax_q[b] <= tag_out.y;
`ifdef CONTOUR_BIN_READER_CENTROID_EN
                    sum_x_q[b] <= sum_x_q[b] + SUM_X_W'(tag_out.x);
                    sum_y_q[b] <= sum_y_q[b] + SUM_Y_W'(tag_out.y);
`endif
                end
            end
        end
    end

    // Record of the bin under the drain index, plus a non-empty flag per label.
    always_comb begin
        sel      = '0;
        nonempty = '0;
        for (int b = 1; b <= int'(MAX_BIN); b++) begin
            nonempty[b] = (cnt_q[b] != '0);
            if (bin_q == BIN_W'(b)) begin
                sel.count = cnt_q[b];
                sel.xmin  = xmin_q[b];
                sel.xmax  = xmax_q[b];
                sel.ymin  = ymin_q[b];
                sel.ymax  = ymax_q[b];
`ifdef CONTOUR_BIN_READER_CENTROID_EN
                sel.sum_x = sum_x_q[b];
                sel.sum_y = sum_y_q[b];
`endif
            end
        end
    end

    // Wraps to 0 past the top label; nonempty[0] is always 0.
    assign next_bin = bin_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            addr_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            flush_q     <= '0;
            bin_q       <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            start_q <= start;
            if ((state_q != StIdle) && !start) begin
                state_q     <= StIdle;
                addr_q      <= '0;
                x_q         <= '0;
                y_q         <= '0;
                bin_q       <= '0;
                res_valid_q <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !start_q) state_q <= StClear;
                    end
                    StClear: begin
                        addr_q  <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        state_q <= StScan;
                    end
                    StScan: begin
                        if (addr_q == AddrLast) begin
                            flush_q <= '0;
                            state_q <= StFlush;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            if (x_q == XLast) begin
                                x_q <= '0;
                                y_q <= y_q + 1'b1;
                            end else begin
                                x_q <= x_q + 1'b1;
                            end
                        end
                    end
                    StFlush: begin
                        if (flush_q == FlushLast) begin
                            bin_q   <= BIN_W'(1);
                            state_q <= StDrain;
                        end else begin
                            flush_q <= flush_q + 1'b1;
                        end
                    end
                    StDrain: begin
                        if (res_valid_q) begin
                            if (res_ready) begin
                                if (bin_q == MaxBin) begin
                                    res_valid_q <= 1'b0;
                                    done_q      <= 1'b1;
                                    state_q     <= StDone;
                                end else begin
                                    // Present the next bin straight away when it has pixels.
                                    bin_q       <= next_bin;
                                    res_valid_q <= nonempty[next_bin];
                                end
                            end
                        end else if (nonempty[bin_q]) begin
                            res_valid_q <= 1'b1;
                        end else if (bin_q == MaxBin) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            bin_q <= next_bin;
                        end
                    end
                    StDone: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign done           = done_q;
    assign res_valid      = res_valid_q;
    assign bram_addr_read = addr_q;
    assign res_bin        = res_valid_q ? bin_q     : '0;
    assign res_count      = res_valid_q ? sel.count : '0;
    assign res_xmin       = res_valid_q ? sel.xmin  : '0;
    assign res_xmax       = res_valid_q ? sel.xmax  : '0;
    assign res_ymin       = res_valid_q ? sel.ymin  : '0;
    assign res_ymax       = res_valid_q ? sel.ymax  : '0;
    assign res_sum_x      = res_valid_q ? sel.sum_x : '0;
    assign res_sum_y      = res_valid_q ? sel.sum_y : '0;

endmodule

// File: tb/tb_contour_bin_reader.sv
// Bench for contour_bin_reader on an 8x4 frame with a 2-cycle BRAM model.
module tb_contour_bin_reader;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int RL = 2;
    localparam int NB = 7;
`ifdef CONTOUR_BIN_READER_CENTROID_EN
    localparam bit CentroidEn = 1'b1;
`else
    localparam bit CentroidEn = 1'b0;
`endif

    typedef struct {
        int bin;
        int cnt;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int sx;
        int sy;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done;
    logic [18:0] bram_addr_read;
    logic [2:0]  bram_read;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_bin;
    logic [18:0] res_count;
    logic [9:0]  res_xmin;
    logic [9:0]  res_xmax;
    logic [8:0]  res_ymin;
    logic [8:0]  res_ymax;
    logic [27:0] res_sum_x;
    logic [26:0] res_sum_y;

    int   checks   = 0;
    int   failures = 0;
    logic [2:0] mem [W*H];
    logic [2:0] rd_pipe [RL];
    rec_t exp_q[$];
    rec_t got_q[$];
    rec_t cmp_e;
    rec_t cmp_g;

    always #5 clk = ~clk;

    contour_bin_reader #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .READ_LATENCY(RL),
        .MAX_BIN     (NB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .done          (done),
        .bram_addr_read(bram_addr_read),
        .bram_read     (bram_read),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_bin       (res_bin),
        .res_count     (res_count),
        .res_xmin      (res_xmin),
        .res_xmax      (res_xmax),
        .res_ymin      (res_ymin),
        .res_ymax      (res_ymax),
        .res_sum_x     (res_sum_x),
        .res_sum_y     (res_sum_y)
    );

    // BRAM with RL cycles from address to data.
    always @(posedge clk) begin
        rd_pipe[0] <= mem[bram_addr_read[4:0]];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_read = rd_pipe[RL-1];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected records straight from the image: per label, scan all pixels.
    function automatic void build_model();
        exp_q.delete();
        for (int b = 1; b <= NB; b++) begin
            rec_t r;
            r = '{b, 0, W, -1, H, -1, 0, 0};
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    if (int'(mem[y*W+x]) == b) begin
                        r.cnt++;
                        if (x < r.xmin) r.xmin = x;
                        if (x > r.xmax) r.xmax = x;
                        if (y < r.ymin) r.ymin = y;
                        if (y > r.ymax) r.ymax = y;
                        r.sx += x;
                        r.sy += y;
                    end
                end
            end
            if (r.cnt > 0) begin
                if (!CentroidEn) begin
                    r.sx = 0;
                    r.sy = 0;
                end
                exp_q.push_back(r);
            end
        end
    endfunction

    // Every valid cycle: fields must match the head of the expected queue (so they stay
    // stable under backpressure); pop on handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_record", int'(res_bin), 0);
            end else begin
                cmp_e = exp_q[0];
                chk("res_bin", int'(res_bin), cmp_e.bin);
                chk("res_count", int'(res_count), cmp_e.cnt);
                chk("res_xmin", int'(res_xmin), cmp_e.xmin);
                chk("res_xmax", int'(res_xmax), cmp_e.xmax);
                chk("res_ymin", int'(res_ymin), cmp_e.ymin);
                chk("res_ymax", int'(res_ymax), cmp_e.ymax);
                chk("res_sum_x", int'(res_sum_x), cmp_e.sx);
                chk("res_sum_y", int'(res_sum_y), cmp_e.sy);
                if (res_ready) begin
                    cmp_g = '{int'(res_bin), int'(res_count), int'(res_xmin), int'(res_xmax),
                              int'(res_ymin), int'(res_ymax), int'(res_sum_x),
                              int'(res_sum_y)};
                    got_q.push_back(cmp_g);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < W*H; i++) mem[i] = 3'd0;
    endtask

    task automatic set_px(input int x, input int y, input int b);
        mem[y*W+x] = 3'(b);
    endtask

    // One full scan; lat = negedges from raising start until done is seen.
    task automatic run_frame(input string tag, output int lat);
        build_model();
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done_rise"}, int'(done), 1);
        chk({tag, "_records_left"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_held"}, int'(done), 1);
        chk({tag, "_no_retrigger"}, int'(res_valid), 0);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done_clear"}, int'(done), 0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        res_ready = 1'b1;
        clear_mem();
        repeat (2) @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_addr", int'(bram_addr_read), 0);
        chk("rst_xmin", int'(res_xmin), 0);
        chk("rst_ymin", int'(res_ymin), 0);
        chk("rst_count", int'(res_count), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty frame: no records, done after ~32+2+7 cycles.
        clear_mem();
        run_frame("t1", lat);
        chk("t1_nrec", got_q.size(), 0);
        chk("t1_lat_min", int'(lat >= 41), 1);
        chk("t1_lat_max", int'(lat <= 48), 1);

        // Two bins.
        clear_mem();
        set_px(2, 1, 1);
        set_px(5, 3, 1);
        set_px(0, 0, 3);
        run_frame("t2", lat);
        chk("t2_nrec", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t2_r0_bin", got_q[0].bin, 1);
            chk("t2_r0_cnt", got_q[0].cnt, 2);
            chk("t2_r0_xmin", got_q[0].xmin, 2);
            chk("t2_r0_xmax", got_q[0].xmax, 5);
            chk("t2_r0_ymin", got_q[0].ymin, 1);
            chk("t2_r0_ymax", got_q[0].ymax, 3);
            chk("t2_r1_bin", got_q[1].bin, 3);
            chk("t2_r1_cnt", got_q[1].cnt, 1);
            chk("t2_r1_xmax", got_q[1].xmax, 0);
            chk("t2_r1_ymax", got_q[1].ymax, 0);
        end

        // Same image, first record stalled for 5 cycles.
        res_ready = 1'b0;
        fork
            run_frame("t3", lat);
            begin
                int k;
                int first_cnt;
                k = 0;
                while (!res_valid && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                chk("t3_valid_seen", int'(res_valid), 1);
                first_cnt = int'(res_count);
                repeat (4) begin
                    @(negedge clk);
                    chk("t3_stall_valid", int'(res_valid), 1);
                    chk("t3_stall_count", int'(res_count), first_cnt);
                end
                res_ready = 1'b1;
            end
        join
        chk("t3_nrec", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t3_r0_bin", got_q[0].bin, 1);
            chk("t3_r1_bin", got_q[1].bin, 3);
        end

        // Every pixel label 1: the last address must be accumulated.
        for (int i = 0; i < W*H; i++) mem[i] = 3'd1;
        run_frame("t4", lat);
        chk("t4_nrec", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("t4_cnt", got_q[0].cnt, 32);
            chk("t4_xmin", got_q[0].xmin, 0);
            chk("t4_xmax", got_q[0].xmax, 7);
            chk("t4_ymin", got_q[0].ymin, 0);
            chk("t4_ymax", got_q[0].ymax, 3);
        end

        // Abort mid-scan at address 10, then a clean rerun.
        clear_mem();
        set_px(2, 1, 1);
        set_px(5, 3, 1);
        set_px(0, 0, 3);
        set_px(7, 3, 7);
        set_px(4, 2, 7);
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (bram_addr_read != 19'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_addr_reached", int'(bram_addr_read), 10);
        start = 1'b0;
        @(negedge clk);
        chk("t5_abort_valid", int'(res_valid), 0);
        chk("t5_abort_done", int'(done), 0);
        repeat (3) @(negedge clk);
        chk("t5_abort_nrec", got_q.size(), 0);
        run_frame("t5", lat);
        chk("t5_nrec", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t5_r2_bin", got_q[2].bin, 7);
            chk("t5_r2_cnt", got_q[2].cnt, 2);
            chk("t5_r2_xmin", got_q[2].xmin, 4);
            chk("t5_r2_ymin", got_q[2].ymin, 2);
        end

        // Centroid sums for bin 2 at (1,1),(3,2).
        clear_mem();
        set_px(1, 1, 2);
        set_px(3, 2, 2);
        run_frame("t6", lat);
        chk("t6_nrec", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("t6_bin", got_q[0].bin, 2);
            chk("t6_sum_x", got_q[0].sx, CentroidEn ? 4 : 0);
            chk("t6_sum_y", got_q[0].sy, CentroidEn ? 3 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
